// File: rtl/mem_stage.sv
// Pipeline memory stage: ALU pass-through, stores, 3-cycle loads from a single-port sync RAM.
// Latency: ALU/store/illegal complete 1 cycle after acceptance; loads complete 3 cycles after.
// Backpressure: stall_out is high while a load is in flight; inputs are ignored until it drops.
module mem_stage #(
    parameter int ARQ    = 16,
    parameter int ADDR_W = 8,
    parameter int RD_W   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [ARQ-1:0]  alu_result,
    input  logic [ARQ-1:0]  store_data,
    input  logic [RD_W-1:0] rd_in,
    input  logic            wb_enable_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    output logic            stall_out,
    output logic            valid_out,
    output logic            wb_enable_out,
    output logic [RD_W-1:0] rd_out,
    output logic [ARQ-1:0]  wb_data_out,
    output logic            err_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [RD_W-1:0]   rd_q;
    logic [ARQ-1:0]    ram_q;
    logic [ARQ-1:0]    mem [DEPTH];

    logic              is_alu, is_load, is_store, is_bad;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic              unused_hi_addr;

    // Upper address bits are deliberately dropped: the RAM wraps.
    assign unused_hi_addr = ^alu_result[ARQ-1:ADDR_W];

    assign stall_out = (state_q != IDLE);

    always_comb begin
        is_alu   = valid_in && !mem_read_in && !mem_write_in;
        is_load  = valid_in &&  mem_read_in && !mem_write_in;
        is_store = valid_in && !mem_read_in &&  mem_write_in;
        is_bad   = valid_in &&  mem_read_in &&  mem_write_in;
    end

    always_comb begin
        state_d  = state_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = addr_q;
        case (state_q)
            IDLE: begin
                ram_addr = alu_result[ADDR_W-1:0];
                ram_we   = is_store && !rst;
                if (is_load) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                ram_re  = !rst;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single-port RAM: one access per cycle, never reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= store_data;
        end
        if (ram_re) begin
            ram_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            rd_q          <= '0;
            valid_out     <= 1'b0;
            wb_enable_out <= 1'b0;
            rd_out        <= '0;
            wb_data_out   <= '0;
            err_out       <= 1'b0;
        end else begin
            state_q       <= state_d;
            valid_out     <= 1'b0;
            wb_enable_out <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_load) begin
                        addr_q <= alu_result[ADDR_W-1:0];
                        rd_q   <= rd_in;
                    end
                    if (is_alu) begin
                        valid_out     <= 1'b1;
                        wb_enable_out <= wb_enable_in;
                        rd_out        <= rd_in;
                        wb_data_out   <= alu_result;
                    end
                    if (is_store || is_bad) begin
                        valid_out <= 1'b1;
                    end
                    if (is_bad) begin
                        err_out <= 1'b1;
                    end
                end
                DONE: begin
                    valid_out     <= 1'b1;
                    wb_enable_out <= 1'b1;
                    rd_out        <= rd_q;
                    wb_data_out   <= ram_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
